// File: rtl/emulib_rammodel_timing_queue_if.sv
// emulib_rammodel_timing_queue_if: request/completion/release handshakes of the RAM-model timing queue
interface emulib_rammodel_timing_queue_if #(parameter int ID_WIDTH = 4);
  logic                areq_valid;
  logic                areq_ready;
  logic                areq_write;
  logic [ID_WIDTH-1:0] areq_id;
  logic [7:0]          areq_len;
  logic                wdone_valid;
  logic                wdone_ready;
  logic                rreq_valid;
  logic                rreq_ready;
  logic [ID_WIDTH-1:0] rreq_id;
  logic [7:0]          rreq_len;
  logic                breq_valid;
  logic                breq_ready;
  logic [ID_WIDTH-1:0] breq_id;
  modport master (
    output areq_valid, areq_write, areq_id, areq_len, wdone_valid, rreq_ready, breq_ready,
    input  areq_ready, wdone_ready, rreq_valid, rreq_id, rreq_len, breq_valid, breq_id
  );
  modport slave (
    input  areq_valid, areq_write, areq_id, areq_len, wdone_valid, rreq_ready, breq_ready,
    output areq_ready, wdone_ready, rreq_valid, rreq_id, rreq_len, breq_valid, breq_id
  );
endinterface

// File: rtl/emulib_rammodel_timing_queue.sv
// emulib_rammodel_timing_queue: per-direction delay FIFOs releasing reads and wdone-gated write responses in order
// Optional read bandwidth limiting with EMULIB_RAMMODEL_BW_LIMIT_EN.
module emulib_rammodel_timing_queue #(
  parameter int ID_WIDTH  = 4,
  parameter int DEPTH     = 8,
  parameter int R_DELAY   = 25,
  parameter int W_DELAY   = 3,
  parameter int DLY_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  emulib_rammodel_timing_queue_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DLY_WIDTH-1:0] RD = DLY_WIDTH'(R_DELAY - 1);
  localparam logic [DLY_WIDTH-1:0] WD = DLY_WIDTH'(W_DELAY - 1);
  localparam logic [AW:0] FULLX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] WMAX = (AW+1)'(DEPTH);
  logic [AW:0]           r_rwp, r_rrp, r_wwp, r_wrp, r_wdone;
  logic [ID_WIDTH-1:0]   r_rid [DEPTH];
  logic [7:0]            r_rlen [DEPTH];
  logic [DLY_WIDTH-1:0]  r_rdly [DEPTH];
  logic [ID_WIDTH-1:0]   r_wid [DEPTH];
  logic [DLY_WIDTH-1:0]  r_wdly [DEPTH];
  logic [AW-1:0] w_rhead, w_whead;
  logic w_rfull, w_wfull, w_rempty, w_wempty, w_aready;
  logic w_renq, w_wenq, w_rvld, w_bvld, w_rdeq, w_bdeq;
  logic w_wd_rdy, w_wd_inc, w_bw_ok;
  always_comb begin
    w_rhead  = r_rrp[AW-1:0];
    w_whead  = r_wrp[AW-1:0];
    w_rfull  = (r_rwp ^ r_rrp) == FULLX;
    w_wfull  = (r_wwp ^ r_wrp) == FULLX;
    w_rempty = r_rwp == r_rrp;
    w_wempty = r_wwp == r_wrp;
    w_aready = !rst && (s.areq_write ? !w_wfull : !w_rfull);
    w_renq   = s.areq_valid && w_aready && !s.areq_write;
    w_wenq   = s.areq_valid && w_aready && s.areq_write;
    w_rvld   = !w_rempty && r_rdly[w_rhead] == '0 && w_bw_ok;
    w_bvld   = !w_wempty && r_wdly[w_whead] == '0 && r_wdone != '0;
    w_rdeq   = w_rvld && s.rreq_ready;
    w_bdeq   = w_bvld && s.breq_ready;
    w_wd_rdy = !rst && r_wdone < WMAX;
    w_wd_inc = s.wdone_valid && w_wd_rdy;
  end
  assign s.areq_ready  = w_aready;
  assign s.wdone_ready = w_wd_rdy;
  assign s.rreq_valid  = w_rvld;
  assign s.rreq_id     = w_rvld ? r_rid[w_rhead] : '0;
  assign s.rreq_len    = w_rvld ? r_rlen[w_rhead] : '0;
  assign s.breq_valid  = w_bvld;
  assign s.breq_id     = w_bvld ? r_wid[w_whead] : '0;
  // Every slot counts down regardless of occupancy; a slot is reloaded when it is enqueued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rwp   <= '0;
      r_rrp   <= '0;
      r_wwp   <= '0;
      r_wrp   <= '0;
      r_wdone <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdly[i] <= '0;
        r_wdly[i] <= '0;
      end
    end else begin
      if (w_renq) r_rwp <= r_rwp + 1'b1;
      if (w_rdeq) r_rrp <= r_rrp + 1'b1;
      if (w_wenq) r_wwp <= r_wwp + 1'b1;
      if (w_bdeq) r_wrp <= r_wrp + 1'b1;
      r_wdone <= r_wdone + (AW+1)'(w_wd_inc) - (AW+1)'(w_bdeq);
      for (int i = 0; i < DEPTH; i++) begin
        r_rdly[i] <= (w_renq && AW'(i) == r_rwp[AW-1:0]) ? RD : (r_rdly[i] != '0 ? r_rdly[i] - 1'b1 : '0);
        r_wdly[i] <= (w_wenq && AW'(i) == r_wwp[AW-1:0]) ? WD : (r_wdly[i] != '0 ? r_wdly[i] - 1'b1 : '0);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_renq) begin
      r_rid[r_rwp[AW-1:0]]  <= s.areq_id;
      r_rlen[r_rwp[AW-1:0]] <= s.areq_len;
    end
    if (w_wenq) r_wid[r_wwp[AW-1:0]] <= s.areq_id;
  end
`ifdef EMULIB_RAMMODEL_BW_LIMIT_EN
  // One data beat per cycle: a released burst of len L blocks the next read for L cycles.
  logic [7:0] r_busy;
  assign w_bw_ok = r_busy == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else if (w_rdeq) r_busy <= s.rreq_len;
    else if (r_busy != '0) r_busy <= r_busy - 1'b1;
  end
`else
  assign w_bw_ok = 1'b1;
`endif
endmodule
